// File: rtl/ps2_scan_decoder_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Purpose  : Shared constants, FSM state encoding and event record for the
//            PS/2 scan-code set 2 decoder.
// Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  // Prefix and status bytes seen on the PS/2 receive stream
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  // Base codes of the modifier keys that are tracked locally
  localparam logic [7:0] KEY_LSHIFT = 8'h12;
  localparam logic [7:0] KEY_RSHIFT = 8'h59;
  localparam logic [7:0] KEY_CAPS   = 8'h58;

  // Remaining bytes of the Pause sequence after its leading E1
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EXT    = 3'd1,
    BRK    = 3'd2,
    EXTBRK = 3'd3,
    SKIP   = 3'd4
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  // Keyboard error bytes abort any partial sequence
  function automatic logic is_err(input logic [7:0] b);
    return (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

  // Bytes that carry device status rather than key information
  function automatic logic is_status(input logic [7:0] b);
    return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_RESEND) ||
           (b == PS2_ECHO) || is_err(b);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_scan_decoder_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_scan_decoder_ctrl_if
// Purpose  : Byte input, event handshake and status bundle of the decoder.
//            slave = decoder side, master = receiver/consumer side.
// Revision : 1.0 - initial release
// ============================================================================
interface ps2_scan_decoder_ctrl_if #(
  parameter int FIFO_DEPTH = 8
);
  logic [7:0]                    scan_code;
  logic                          scan_ready;
  logic                          ev_valid;
  logic                          ev_ready;
  logic [7:0]                    ev_code;
  logic                          ev_ext;
  logic                          ev_break;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          overflow;
  logic                          shift_held;
  logic                          caps_lock;

  modport slave (
    input  scan_code, scan_ready, ev_ready,
    output ev_valid, ev_code, ev_ext, ev_break, fifo_count, overflow,
           shift_held, caps_lock
  );

  modport master (
    output scan_code, scan_ready, ev_ready,
    input  ev_valid, ev_code, ev_ext, ev_break, fifo_count, overflow,
           shift_held, caps_lock
  );
endinterface
`default_nettype wire

// File: rtl/ps2_scan_decoder_ctrl_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_evt_fifo
// Purpose  : Synchronous FIFO. A push while full is accepted only when a pop
//            happens in the same cycle; a pop while empty is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  wire logic                       clk,
  input  wire logic                       reset,
  input  wire logic                       push_i,
  input  wire logic [WIDTH-1:0]           push_data_i,
  input  wire logic                       pop_i,
  output logic      [WIDTH-1:0]           pop_data_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic      [$clog2(DEPTH):0]     count_o
);

  localparam int                  AW       = $clog2(DEPTH);
  localparam logic [AW:0]         FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_pop;
  logic             do_push;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == FULL_CNT);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a full FIFO can still accept
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Storage array; no reset needed, contents are qualified by the count
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_scan_decoder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ps2_scan_decoder_ctrl
// Purpose  : Turns a PS/2 set-2 byte stream into key events (E0/F0 prefixes
//            collapsed, Pause and status bytes swallowed), tracks Shift and
//            Caps Lock, and queues events for a valid/ready consumer.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_scan_decoder_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  wire logic              clk,
  input  wire logic              reset,
  ps2_scan_decoder_ctrl_if.slave bus
);

  localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam int                CNT_W    = $clog2(FIFO_DEPTH) + 1;

  ps2_state_e        state_q;
  logic [2:0]        skip_cnt_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              push_q;
  ps2_evt_t          evt_q;
  logic              emit_d;
  ps2_evt_t          evt_d;
  logic              lshift_q;
  logic              rshift_q;
  logic              caps_held_q;
  logic              caps_lock_q;
  logic              overflow_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  ps2_evt_t          head;
  logic              pop;

  // Decide whether the current byte completes a key event and what it is
  always_comb begin
    emit_d     = 1'b0;
    evt_d.ext  = (state_q == EXT) || (state_q == EXTBRK);
    evt_d.brk  = (state_q == BRK) || (state_q == EXTBRK);
    evt_d.code = bus.scan_code;
    if (bus.scan_ready) begin
      case (state_q)
        IDLE:        emit_d = (bus.scan_code != PS2_EXT) && (bus.scan_code != PS2_BRK) &&
                              (bus.scan_code != PS2_PAUSE) && !is_status(bus.scan_code);
        EXT:         emit_d = (bus.scan_code != PS2_BRK) && (bus.scan_code != PS2_EXT) &&
                              !is_err(bus.scan_code);
        BRK, EXTBRK: emit_d = !is_err(bus.scan_code);
        default:     emit_d = 1'b0;
      endcase
    end
  end

  // Prefix sequencer with inactivity timeout; registers the event to push
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      skip_cnt_q <= '0;
      tmo_q      <= '0;
      push_q     <= 1'b0;
      evt_q      <= '0;
    end else begin
      push_q <= emit_d;
      if (emit_d) evt_q <= evt_d;
      if (bus.scan_ready) begin
        tmo_q <= '0;
        case (state_q)
          IDLE: begin
            if (bus.scan_code == PS2_EXT) begin
              state_q <= EXT;
            end else if (bus.scan_code == PS2_BRK) begin
              state_q <= BRK;
            end else if (bus.scan_code == PS2_PAUSE) begin
              state_q    <= SKIP;
              skip_cnt_q <= PAUSE_TAIL;
            end
          end
          EXT: begin
            if (bus.scan_code == PS2_BRK) begin
              state_q <= EXTBRK;
            end else if (bus.scan_code != PS2_EXT) begin
              state_q <= IDLE;
            end
          end
          BRK, EXTBRK: state_q <= IDLE;
          SKIP: begin
            skip_cnt_q <= skip_cnt_q - 1'b1;
            if (skip_cnt_q == 3'd1) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q == IDLE) begin
        tmo_q <= '0;
      end else if (tmo_q == TMO_LAST) begin
        state_q <= IDLE;
        tmo_q   <= '0;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end
    end
  end

  // Modifier state follows every completed event, even one the FIFO drops
  always_ff @(posedge clk) begin
    if (reset) begin
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_held_q <= 1'b0;
      caps_lock_q <= 1'b0;
    end else if (emit_d && !evt_d.ext) begin
      if (evt_d.code == KEY_LSHIFT) lshift_q <= !evt_d.brk;
      if (evt_d.code == KEY_RSHIFT) rshift_q <= !evt_d.brk;
      if (evt_d.code == KEY_CAPS) begin
        caps_held_q <= !evt_d.brk;
        // Only the first make of a press toggles; typematic repeats do not
        if (!evt_d.brk && !caps_held_q) caps_lock_q <= !caps_lock_q;
      end
    end
  end

  // Sticky flag for events lost to a full FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (push_q && fifo_full && !pop) begin
      overflow_q <= 1'b1;
    end
  end

  assign pop = bus.ev_valid & bus.ev_ready;

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(ps2_evt_t))
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_q),
    .push_data_i (evt_q),
    .pop_i       (pop),
    .pop_data_o  (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Head fields read as zero whenever nothing is queued
  assign bus.ev_valid   = !fifo_empty;
  assign bus.ev_code    = fifo_empty ? 8'h00 : head.code;
  assign bus.ev_ext     = !fifo_empty && head.ext;
  assign bus.ev_break   = !fifo_empty && head.brk;
  assign bus.fifo_count = fifo_count;
  assign bus.overflow   = overflow_q;
  assign bus.shift_held = lshift_q | rshift_q;
  assign bus.caps_lock  = caps_lock_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scan_decoder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_scan_decoder_ctrl
// Purpose  : Directed self-checking bench for the PS/2 scan decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_scan_decoder_ctrl;

  localparam int DEPTH = 8;
  localparam int TMO   = 64;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  ps2_scan_decoder_ctrl_if #(.FIFO_DEPTH(DEPTH)) bus ();

  ps2_scan_decoder_ctrl #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Drive one byte for exactly one cycle (call at a falling edge)
  task automatic send_byte(input logic [7:0] b);
    bus.scan_code  = b;
    bus.scan_ready = 1'b1;
    @(negedge clk);
    bus.scan_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_one();
    bus.ev_ready = 1'b1;
    @(negedge clk);
    bus.ev_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.ev_valid, bus.overflow, bus.shift_held, bus.caps_lock} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got valid/ovf/shift/caps=%b want 0000",
               {bus.ev_valid, bus.overflow, bus.shift_held, bus.caps_lock});
    end
    checks++;
    if (bus.fifo_count !== 4'd0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", bus.fifo_count);
    end
    checks++;
    if ({bus.ev_ext, bus.ev_break, bus.ev_code} !== 10'h000) begin
      errors++; $display("FAIL reset_head: got %h want 000", {bus.ev_ext, bus.ev_break, bus.ev_code});
    end
  endtask

  task automatic test_single_make();
    send_byte(8'h1C);
    checks++;
    if (bus.ev_valid !== 1'b0) begin
      errors++; $display("FAIL single_latency1: ev_valid got %b want 0", bus.ev_valid);
    end
    idle(1);
    checks++;
    if (bus.ev_valid !== 1'b1) begin
      errors++; $display("FAIL single_latency2: ev_valid got %b want 1", bus.ev_valid);
    end
    checks++;
    if ({bus.ev_ext, bus.ev_break, bus.ev_code} !== {2'b00, 8'h1C}) begin
      errors++; $display("FAIL single_event: got %h want 01c", {bus.ev_ext, bus.ev_break, bus.ev_code});
    end
    idle(2);
    checks++;
    if (bus.fifo_count !== 4'd1 || bus.ev_code !== 8'h1C) begin
      errors++; $display("FAIL single_hold: count %0d code %h want 1 1c", bus.fifo_count, bus.ev_code);
    end
    pop_one();
    checks++;
    if (bus.fifo_count !== 4'd0 || bus.ev_valid !== 1'b0) begin
      errors++; $display("FAIL single_pop: count %0d valid %b want 0 0", bus.fifo_count, bus.ev_valid);
    end
  endtask

  task automatic test_ext_break();
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    idle(2);
    checks++;
    if (bus.fifo_count !== 4'd1 || {bus.ev_ext, bus.ev_break, bus.ev_code} !== {2'b11, 8'h75}) begin
      errors++; $display("FAIL ext_break: count %0d event %h want 1 375",
                         bus.fifo_count, {bus.ev_ext, bus.ev_break, bus.ev_code});
    end
    pop_one();
    // A plain byte next must be a make: the sequencer is back in IDLE
    send_byte(8'h1C);
    idle(2);
    checks++;
    if ({bus.ev_ext, bus.ev_break, bus.ev_code} !== {2'b00, 8'h1C} || bus.fifo_count !== 4'd1) begin
      errors++; $display("FAIL ext_break_idle: event %h count %0d want 01c 1",
                         {bus.ev_ext, bus.ev_break, bus.ev_code}, bus.fifo_count);
    end
    pop_one();
  endtask

  task automatic test_pause();
    logic [7:0] seq [9];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};
    for (int i = 0; i < 9; i++) send_byte(seq[i]);
    idle(2);
    checks++;
    if (bus.fifo_count !== 4'd1 || {bus.ev_ext, bus.ev_break, bus.ev_code} !== {2'b00, 8'h1C}) begin
      errors++; $display("FAIL pause_swallow: count %0d event %h want 1 01c",
                         bus.fifo_count, {bus.ev_ext, bus.ev_break, bus.ev_code});
    end
    pop_one();
    // Status bytes in IDLE produce nothing
    send_byte(8'hAA); send_byte(8'hFA); send_byte(8'hFF);
    idle(2);
    checks++;
    if (bus.fifo_count !== 4'd0) begin
      errors++; $display("FAIL status_discard: count %0d want 0", bus.fifo_count);
    end
  endtask

  task automatic test_modifiers();
    logic [9:0] exp [6];
    exp = '{{2'b00, 8'h12}, {2'b00, 8'h58}, {2'b00, 8'h58},
            {2'b01, 8'h58}, {2'b00, 8'h58}, {2'b01, 8'h12}};
    send_byte(8'h12);
    checks++;
    if (bus.shift_held !== 1'b1 || bus.caps_lock !== 1'b0) begin
      errors++; $display("FAIL mod_shift_make: shift %b caps %b want 1 0", bus.shift_held, bus.caps_lock);
    end
    send_byte(8'h58);
    checks++;
    if (bus.caps_lock !== 1'b1) begin
      errors++; $display("FAIL mod_caps_on: got %b want 1", bus.caps_lock);
    end
    send_byte(8'h58);
    checks++;
    if (bus.caps_lock !== 1'b1) begin
      errors++; $display("FAIL mod_caps_repeat: got %b want 1", bus.caps_lock);
    end
    send_byte(8'hF0); send_byte(8'h58);
    send_byte(8'h58);
    checks++;
    if (bus.caps_lock !== 1'b0) begin
      errors++; $display("FAIL mod_caps_off: got %b want 0", bus.caps_lock);
    end
    send_byte(8'hF0); send_byte(8'h12);
    checks++;
    if (bus.shift_held !== 1'b0) begin
      errors++; $display("FAIL mod_shift_break: got %b want 0", bus.shift_held);
    end
    idle(2);
    checks++;
    if (bus.fifo_count !== 4'd6) begin
      errors++; $display("FAIL mod_count: got %0d want 6", bus.fifo_count);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({bus.ev_ext, bus.ev_break, bus.ev_code} !== exp[i]) begin
        errors++; $display("FAIL mod_event%0d: got %h want %h", i,
                           {bus.ev_ext, bus.ev_break, bus.ev_code}, exp[i]);
      end
      pop_one();
    end
  endtask

  task automatic test_timeout();
    send_byte(8'hF0);
    idle(10);
    send_byte(8'h1C);
    idle(2);
    checks++;
    if ({bus.ev_ext, bus.ev_break, bus.ev_code} !== {2'b01, 8'h1C}) begin
      errors++; $display("FAIL timeout_short_gap: got %h want 11c", {bus.ev_ext, bus.ev_break, bus.ev_code});
    end
    pop_one();
    send_byte(8'hF0);
    idle(TMO + 2);
    send_byte(8'h1C);
    idle(2);
    checks++;
    if ({bus.ev_ext, bus.ev_break, bus.ev_code} !== {2'b00, 8'h1C} || bus.fifo_count !== 4'd1) begin
      errors++; $display("FAIL timeout_abandon: event %h count %0d want 01c 1",
                         {bus.ev_ext, bus.ev_break, bus.ev_code}, bus.fifo_count);
    end
    pop_one();
  endtask

  task automatic test_overflow();
    logic [7:0] exp [8];
    exp = '{8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h21};
    for (int i = 0; i < 10; i++) send_byte(8'h15 + 8'(i));
    idle(2);
    checks++;
    if (bus.fifo_count !== 4'd8 || bus.overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_full: count %0d ovf %b want 8 1", bus.fifo_count, bus.overflow);
    end
    checks++;
    if (bus.ev_code !== 8'h15) begin
      errors++; $display("FAIL ovf_head: got %h want 15", bus.ev_code);
    end
    // Push lands on the same edge as a pop of the full FIFO
    send_byte(8'h21);
    bus.ev_ready = 1'b1;
    @(negedge clk);
    bus.ev_ready = 1'b0;
    checks++;
    if (bus.fifo_count !== 4'd8) begin
      errors++; $display("FAIL ovf_push_pop: count %0d want 8", bus.fifo_count);
    end
    bus.ev_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.ev_valid !== 1'b1 || bus.ev_code !== exp[i]) begin
        errors++; $display("FAIL ovf_order%0d: valid %b code %h want 1 %h", i, bus.ev_valid, bus.ev_code, exp[i]);
      end
      @(negedge clk);
    end
    bus.ev_ready = 1'b0;
    checks++;
    if (bus.fifo_count !== 4'd0 || bus.ev_valid !== 1'b0) begin
      errors++; $display("FAIL ovf_drained: count %0d valid %b want 0 0", bus.fifo_count, bus.ev_valid);
    end
  endtask

  task automatic test_reset_midstream();
    send_byte(8'h12); send_byte(8'hF0); send_byte(8'h58); send_byte(8'h58);
    send_byte(8'h1D); send_byte(8'hF0);
    idle(2);
    checks++;
    if (bus.shift_held !== 1'b1 || bus.caps_lock !== 1'b1 || bus.overflow !== 1'b1 || bus.ev_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset: shift %b caps %b ovf %b valid %b want 1111",
                         bus.shift_held, bus.caps_lock, bus.overflow, bus.ev_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({bus.ev_valid, bus.overflow, bus.shift_held, bus.caps_lock} !== 4'b0000 ||
        bus.fifo_count !== 4'd0 || {bus.ev_ext, bus.ev_break, bus.ev_code} !== 10'h000) begin
      errors++; $display("FAIL mid_reset: flags %b count %0d head %h want 0000 0 000",
                         {bus.ev_valid, bus.overflow, bus.shift_held, bus.caps_lock},
                         bus.fifo_count, {bus.ev_ext, bus.ev_break, bus.ev_code});
    end
    // Pending F0 must have been forgotten
    send_byte(8'h1C);
    idle(2);
    checks++;
    if ({bus.ev_ext, bus.ev_break, bus.ev_code} !== {2'b00, 8'h1C}) begin
      errors++; $display("FAIL mid_reset_idle: got %h want 01c", {bus.ev_ext, bus.ev_break, bus.ev_code});
    end
    pop_one();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    bus.scan_code  = 8'h00;
    bus.scan_ready = 1'b0;
    bus.ev_ready   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_single_make();
    test_ext_break();
    test_pause();
    test_modifiers();
    test_timeout();
    test_overflow();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_scan_decoder_ctrl.md
Name: ps2_scan_decoder_ctrl

Overview:
Sequences the raw byte stream from the PS/2 receiver (scan_code / scan_ready, scan-code set 2) into complete key events. Collapses E0 (extended) and F0 (break) prefixes. Swallows the 8-byte Pause sequence and device status bytes. Tracks Shift and Caps Lock state and buffers events in a small FIFO with a valid/ready consumer handshake. Sits between the PS/2 receiver and the downstream key consumer (display/game logic).

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of two, >= 2
TIMEOUT_CYCLES, 50000, clk cycles without a byte after which a partial prefix sequence is abandoned (1 ms at 50 MHz)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
scan_code  in  8  byte from PS/2 receiver, valid when scan_ready=1
scan_ready  in  1  single-cycle strobe, one per received byte
ev_valid  out  1  event available at FIFO head
ev_ready  in  1  consumer accepts head event when ev_valid & ev_ready
ev_code  out  8  base scan code of head event
ev_ext  out  1  head event was E0-prefixed
ev_break  out  1  head event is a release (F0-prefixed)
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently held
overflow  out  1  sticky: an event was dropped because the FIFO was full
shift_held  out  1  either Shift key currently pressed
caps_lock  out  1  Caps Lock toggle state

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset.
- Reset values: ev_valid=0, fifo_count=0, overflow=0, shift_held=0, caps_lock=0, FSM=IDLE, FIFO emptied. ev_code/ev_ext/ev_break=0.
- FSM acts only on cycles with scan_ready=1, except for timeout.
  - IDLE:
    - E0 -> EXT
    - F0 -> BRK
    - E1 -> SKIP, skip_cnt=7
    - AA/FA/FE/EE/00/FF -> discarded, stay IDLE
    - other -> push {ext=0,brk=0,code}
  - EXT:
    - F0 -> EXTBRK
    - E0 -> stay EXT
    - 00/FF -> IDLE, no push
    - other -> push {1,0,code}, then IDLE
  - BRK:
    - 00/FF -> IDLE, no push
    - other -> push {0,1,code}, then IDLE
  - EXTBRK:
    - 00/FF -> IDLE, no push
    - other -> push {1,1,code}, then IDLE
  - SKIP: each byte decrements skip_cnt; the byte that makes skip_cnt 0 returns to IDLE. No pushes while in SKIP.
- Timeout:
  - Counter clears on every scan_ready and while in IDLE.
  - In any non-IDLE state, reaching TIMEOUT_CYCLES-1 forces IDLE. The partial sequence is discarded, no push.
- Latency: the event is written to the FIFO on the clk edge after the final byte's scan_ready. ev_valid is asserted the following cycle (registered head).
- FIFO behaviour:
  - A push with the FIFO full and no pop in the same cycle is dropped and sets overflow=1 until reset.
  - A push and pop in the same cycle while full are both accepted; the count is unchanged.
  - A pop while empty is ignored.
  - Head outputs hold stable while ev_valid=1 and ev_ready=0.
- Modifier tracking is updated at the push decision, independent of FIFO fullness:
  - shift_held is the OR of lshift (code 12, ext=0) and rshift (code 59, ext=0) held flags. Make sets the flag; break clears it.
  - caps_lock toggles on make of 58 (ext=0) only when caps_held=0. caps_held is set on make and cleared on break, so typematic repeats do not retoggle.
- scan_ready pulses arriving back-to-back on consecutive cycles must all be processed; no byte may be lost.

Decomposition:
- Package ps2_pkg holds:
  - byte constants: PS2_EXT=E0, PS2_BRK=F0, PS2_PAUSE=E1, PS2_BAT_OK=AA, PS2_ACK=FA, PS2_RESEND=FE, PS2_ECHO=EE, PS2_ERR0=00, PS2_ERR1=FF
  - key constants: KEY_LSHIFT=12, KEY_RSHIFT=59, KEY_CAPS=58
  - FSM state enum {IDLE,EXT,BRK,EXTBRK,SKIP}
  - 10-bit event struct {ext,brk,code}
- One sub-module: ps2_evt_fifo, a synchronous FIFO parameterised on depth and width, exposing full/empty/count. Push/pop semantics are as stated above.

Test Plan:
- Byte stream 1C -> one event {code=1C, ext=0, brk=0}; ev_valid rises 2 cycles after scan_ready; fifo_count=1 until popped.
- Byte stream E0 F0 75 -> exactly one event {75, ext=1, brk=1}; FSM back in IDLE.
- Byte stream E1 14 77 E1 F0 14 F0 77 then 1C -> only event is {1C,0,0}.
- Bytes 12, 58, 58, F0 58, 58, F0 12 -> shift_held goes 1 then 0; caps_lock goes 0->1 on first 58 and 1->0 on third 58; six events queued.
- Byte F0, then no scan_ready for TIMEOUT_CYCLES, then 1C -> event {1C,0,0}, not a break.
- Ten make codes with ev_ready=0 and FIFO_DEPTH=8 -> fifo_count=8, overflow=1, first eight codes are popped in order. Then hold ev_ready=1 with a push on a full FIFO -> count stays 8 and no drop occurs. Assert reset mid-stream -> all outputs return to reset values the next cycle.
